// File: rtl/mouse_click_filter.sv
// Conditions raw mouse buttons: 2-FF synchronise, debounce, press/release pulses,
// and capture of the cursor position at each accepted left press.

module mouse_click_filter #(
    parameter int DEBOUNCE_CYCLES = 650_000,
    parameter int CNT_W           = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        left_raw,
    input  logic        right_raw,
    input  logic [11:0] xpos_in,
    input  logic [11:0] ypos_in,
    output logic        left_level,
    output logic        right_level,
    output logic        left_press,
    output logic        left_release,
    output logic        right_press,
    output logic        right_release,
    output logic [11:0] click_x,
    output logic [11:0] click_y
);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_PEND,
        HELD,
        RELEASE_PEND
    } state_t;

    localparam int LEFT  = 0;
    localparam int RIGHT = 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       raw;
    logic [1:0]       meta_q;
    logic [1:0]       sync_q;
    logic [1:0]       level_q;
    logic [1:0]       press_q;
    logic [1:0]       release_q;
    state_t           state_q [2];
    logic [CNT_W-1:0] cnt_q   [2];
    logic [11:0]      click_x_q;
    logic [11:0]      click_y_q;
    logic             left_accept;

    assign raw = {right_raw, left_raw};

    // NOTE: non-blocking assignments make sync_q take the previous meta_q, so the
    // two flops form a real two-stage pipeline instead of collapsing into one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= raw;
            sync_q <= meta_q;
        end
    end

    // Both buttons share one FSM description; index 0 is left, index 1 is right.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            for (int b = 0; b < 2; b++) begin
                state_q[b] <= RELEASED;
                cnt_q[b]   <= '0;
            end
        end else begin
            // NOTE: pulses default low every cycle and are only set on the accepting
            // edge, which guarantees they can never stretch beyond one cycle.
            press_q   <= '0;
            release_q <= '0;
            for (int b = 0; b < 2; b++) begin
                case (state_q[b])
                    RELEASED: begin
                        if (sync_q[b]) begin
                            state_q[b] <= PRESS_PEND;
                            cnt_q[b]   <= CNT_ONE;
                        end
                    end
                    PRESS_PEND: begin
                        if (!sync_q[b]) begin
                            state_q[b] <= RELEASED;
                            cnt_q[b]   <= '0;
                        end else if (cnt_q[b] == CNT_LAST) begin
                            state_q[b] <= HELD;
                            cnt_q[b]   <= '0;
                            level_q[b] <= 1'b1;
                            press_q[b] <= 1'b1;
                        end else begin
                            cnt_q[b] <= cnt_q[b] + CNT_ONE;
                        end
                    end
                    HELD: begin
                        if (!sync_q[b]) begin
                            state_q[b] <= RELEASE_PEND;
                            cnt_q[b]   <= CNT_ONE;
                        end
                    end
                    RELEASE_PEND: begin
                        if (sync_q[b]) begin
                            state_q[b] <= HELD;
                            cnt_q[b]   <= '0;
                        end else if (cnt_q[b] == CNT_LAST) begin
                            state_q[b]   <= RELEASED;
                            cnt_q[b]     <= '0;
                            level_q[b]   <= 1'b0;
                            release_q[b] <= 1'b1;
                        end else begin
                            cnt_q[b] <= cnt_q[b] + CNT_ONE;
                        end
                    end
                    default: begin
                        state_q[b] <= RELEASED;
                        cnt_q[b]   <= '0;
                        level_q[b] <= 1'b0;
                    end
                endcase
            end
        end
    end

    // True on exactly the edge that raises left_press, so the capture lines up with it.
    assign left_accept = (state_q[LEFT] == PRESS_PEND) && sync_q[LEFT] &&
                         (cnt_q[LEFT] == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            click_x_q <= '0;
            click_y_q <= '0;
        end else if (left_accept) begin
            click_x_q <= xpos_in;
            click_y_q <= ypos_in;
        end
    end

    assign left_level    = level_q[LEFT];
    assign right_level   = level_q[RIGHT];
    assign left_press    = press_q[LEFT];
    assign left_release  = release_q[LEFT];
    assign right_press   = press_q[RIGHT];
    assign right_release = release_q[RIGHT];
    assign click_x       = click_x_q;
    assign click_y       = click_y_q;

endmodule

// File: tb/tb_mouse_click_filter.sv
// Self-checking bench for mouse_click_filter: directed scenarios plus randomized
// button activity against a sample-history reference model.

module tb_mouse_click_filter;

    localparam int DC = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        left_raw;
    logic        right_raw;
    logic [11:0] xpos_in;
    logic [11:0] ypos_in;
    logic        left_level;
    logic        right_level;
    logic        left_press;
    logic        left_release;
    logic        right_press;
    logic        right_release;
    logic [11:0] click_x;
    logic [11:0] click_y;

    int total = 0;
    int bad   = 0;

    // Reference model state; bit 1 = left, bit 0 = right.
    logic [1:0]    m_pipe [$];
    logic [DC-1:0] m_hist [2];
    logic [1:0]    m_lvl;
    logic [1:0]    m_press;
    logic [1:0]    m_rel;
    logic [11:0]   m_cx;
    logic [11:0]   m_cy;

    mouse_click_filter #(
        .DEBOUNCE_CYCLES(DC),
        .CNT_W          (3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .left_raw     (left_raw),
        .right_raw    (right_raw),
        .xpos_in      (xpos_in),
        .ypos_in      (ypos_in),
        .left_level   (left_level),
        .right_level  (right_level),
        .left_press   (left_press),
        .left_release (left_release),
        .right_press  (right_press),
        .right_release(right_release),
        .click_x      (click_x),
        .click_y      (click_y)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic model_reset();
        m_pipe.delete();
        m_pipe.push_back(2'b00);
        m_pipe.push_back(2'b00);
        m_hist[0] = '0;
        m_hist[1] = '0;
        m_lvl     = '0;
        m_press   = '0;
        m_rel     = '0;
        m_cx      = '0;
        m_cy      = '0;
    endtask

    // A level flips once the last DC synchronised samples all disagree with it.
    task automatic model_edge();
        logic [1:0] sv;
        sv = m_pipe.pop_front();
        m_pipe.push_back({left_raw, right_raw});
        m_press = '0;
        m_rel   = '0;
        for (int b = 0; b < 2; b++) begin
            m_hist[b] = {m_hist[b][DC-2:0], sv[b]};
            if (m_hist[b] == {DC{~m_lvl[b]}}) begin
                m_lvl[b] = ~m_lvl[b];
                if (m_lvl[b]) m_press[b] = 1'b1;
                else          m_rel[b]   = 1'b1;
            end
        end
        if (m_press[1]) begin
            m_cx = xpos_in;
            m_cy = ypos_in;
        end
    endtask

    task automatic compare_all();
        check("level", {30'd0, left_level, right_level}, {30'd0, m_lvl});
        check("pulse", {28'd0, left_press, left_release, right_press, right_release},
              {28'd0, m_press[1], m_rel[1], m_press[0], m_rel[0]});
        check("click_x", {20'd0, click_x}, {20'd0, m_cx});
        check("click_y", {20'd0, click_y}, {20'd0, m_cy});
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_edge();
        #1;
        compare_all();
    endtask

    task automatic wait_left_press(output int n);
        bit seen;
        seen = 1'b0;
        n    = 99;
        for (int i = 1; i <= 20; i++) begin
            if (!seen) begin
                step();
                if (left_press === 1'b1) begin
                    seen = 1'b1;
                    n    = i;
                end
            end
        end
    endtask

    initial begin
        int n;
        int cnt;
        int lat;
        int p;

        // Reset with the left button already held.
        rst_n     = 1'b0;
        left_raw  = 1'b1;
        right_raw = 1'b0;
        xpos_in   = '0;
        ypos_in   = '0;
        model_reset();
        repeat (3) step();
        rst_n = 1'b1;
        wait_left_press(n);
        check("t1_lat", n, 6);

        // Clean press captures the cursor.
        left_raw = 1'b0;
        repeat (8) step();
        xpos_in  = 12'd300;
        ypos_in  = 12'd200;
        left_raw = 1'b1;
        wait_left_press(n);
        check("t2_lat", n, 6);
        check("t2_cx", {20'd0, click_x}, 300);
        check("t2_cy", {20'd0, click_y}, 200);
        step();
        check("t2_pw", {31'd0, left_press}, 0);
        check("t2_lvl", {31'd0, left_level}, 1);

        // Short glitch is rejected.
        left_raw = 1'b0;
        repeat (8) step();
        xpos_in  = 12'd555;
        ypos_in  = 12'd444;
        left_raw = 1'b1;
        repeat (3) step();
        left_raw = 1'b0;
        cnt = 0;
        repeat (12) begin
            step();
            if (left_press || left_release) cnt++;
        end
        check("t3_pulses", cnt, 0);
        check("t3_lvl", {31'd0, left_level}, 0);
        check("t3_cx", {20'd0, click_x}, 300);

        // Bouncy release yields exactly one release pulse.
        left_raw = 1'b1;
        wait_left_press(n);
        repeat (2) step();
        left_raw = 1'b0;
        step();
        left_raw = 1'b1;
        step();
        left_raw = 1'b0;
        cnt = 0;
        lat = 0;
        for (int i = 1; i <= 16; i++) begin
            step();
            if (left_release) begin
                cnt++;
                if (lat == 0) lat = i;
            end
        end
        check("t4_lat", lat, 6);
        check("t4_cnt", cnt, 1);

        // Simultaneous presses; right-only press leaves the capture alone.
        xpos_in   = 12'd100;
        ypos_in   = 12'd50;
        left_raw  = 1'b1;
        right_raw = 1'b1;
        wait_left_press(n);
        check("t5_lat", n, 6);
        check("t5_rp", {31'd0, right_press}, 1);
        check("t5_cx", {20'd0, click_x}, 100);
        left_raw  = 1'b0;
        right_raw = 1'b0;
        repeat (8) step();
        right_raw = 1'b1;
        cnt = 0;
        repeat (10) begin
            xpos_in = 12'($urandom);
            ypos_in = 12'($urandom);
            step();
            if (right_press) cnt++;
        end
        check("t5_rcnt", cnt, 1);
        check("t5_rlvl", {31'd0, right_level}, 1);
        check("t5_cx2", {20'd0, click_x}, 100);
        check("t5_cy2", {20'd0, click_y}, 50);

        // Reset while held drops the level immediately without a release pulse.
        right_raw = 1'b0;
        left_raw  = 1'b1;
        wait_left_press(n);
        repeat (2) step();
        left_raw = 1'b0;
        rst_n    = 1'b0;
        model_reset();
        #1;
        check("t6_lvl", {31'd0, left_level}, 0);
        check("t6_rel", {31'd0, left_release}, 0);
        compare_all();
        step();
        rst_n = 1'b1;
        cnt = 0;
        repeat (10) begin
            step();
            if (left_release) cnt++;
        end
        check("t6_rcnt", cnt, 0);

        // Randomized activity with varying bounce density and occasional resets.
        p = 1;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) p = int'($urandom_range(12, 1));
            if ($urandom_range(p - 1, 0) == 0) left_raw  = ~left_raw;
            if ($urandom_range(p - 1, 0) == 0) right_raw = ~right_raw;
            xpos_in = 12'($urandom);
            ypos_in = 12'($urandom);
            if ($urandom_range(599, 0) == 0) begin
                rst_n = 1'b0;
                model_reset();
                #1;
                compare_all();
                step();
                rst_n = 1'b1;
            end else begin
                step();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
